// File: rtl/cpu_dma.sv
// cpu_dma: CPU-halting multi-channel DMA with a 16-byte register window.
// Optional CPU_DMA_DST_INC_EN makes the destination increment per byte.
module cpu_dma #(
  parameter int          CHANNELS = 2,
  parameter logic [15:0] REG_BASE = 16'h4010
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [15:0]         i_cpu_a,
  input  logic [7:0]          i_cpu_d,
  input  logic                i_cpu_we,
  input  logic [7:0]          i_din,
  output logic                o_rdy,
  output logic                o_master,
  output logic [15:0]         o_addr,
  output logic [7:0]          o_dout,
  output logic                o_wreq,
  output logic [CHANNELS-1:0] o_busy,
  output logic [CHANNELS-1:0] o_done
);
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  typedef enum logic [2:0] {S_IDLE, S_HALT, S_ALIGN, S_READ, S_WRITE} state_t;
  state_t              r_state;
  logic [7:0]          r_src_hi [CHANNELS];
  logic [7:0]          r_dst_lo [CHANNELS];
  logic [7:0]          r_dst_hi [CHANNELS];
  logic [7:0]          r_len    [CHANNELS];
  logic [CHANNELS-1:0] r_busy, r_done;
  logic                r_par, r_rdy, r_master, r_wreq;
  logic [15:0]         r_addr, r_src, r_dst;
  logic [7:0]          r_dout;
  logic [8:0]          r_cnt;
  logic [CW-1:0]       r_ch;
  logic [CHANNELS-1:0] w_wr, w_pend, w_chmask;
  logic [CW-1:0]       w_nxt;
  logic                w_sel, w_any;
  logic [15:0]         w_ld_src, w_ld_dst, w_src_inc, w_dst_nxt;
  logic [8:0]          w_ld_cnt;
  assign w_sel    = i_cpu_we && (i_cpu_a[15:4] == REG_BASE[15:4]);
  assign w_chmask = CHANNELS'(1) << r_ch;
  // At a channel boundary the finishing channel is excluded from arbitration
  assign w_pend   = (r_state == S_WRITE) ? (r_busy & ~w_chmask) : r_busy;
  assign w_any    = |w_pend;
  always_comb begin
    w_wr  = '0;
    w_nxt = '0;
    for (int c = CHANNELS - 1; c >= 0; c--) begin
      w_wr[c] = w_sel && (i_cpu_a[3:2] == 2'(c)) && !r_busy[c];
      if (w_pend[c]) w_nxt = CW'(c);
    end
  end
  assign w_ld_src  = {r_src_hi[w_nxt], 8'h00};
  assign w_ld_dst  = {r_dst_hi[w_nxt], r_dst_lo[w_nxt]};
  assign w_ld_cnt  = (r_len[w_nxt] == 8'd0) ? 9'd256 : {1'b0, r_len[w_nxt]};
  assign w_src_inc = r_src + 16'd1;
`ifdef CPU_DMA_DST_INC_EN
  assign w_dst_nxt = r_dst + 16'd1;
`else
  assign w_dst_nxt = r_dst;
`endif
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= S_IDLE;
      r_par    <= 1'b0;
      r_rdy    <= 1'b1;
      r_master <= 1'b0;
      r_wreq   <= 1'b0;
      r_addr   <= '0;
      r_dout   <= '0;
      r_busy   <= '0;
      r_done   <= '0;
      r_ch     <= '0;
      r_src    <= '0;
      r_dst    <= '0;
      r_cnt    <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        r_src_hi[c] <= '0;
        r_dst_lo[c] <= '0;
        r_dst_hi[c] <= '0;
        r_len[c]    <= '0;
      end
    end else begin
      r_par  <= ~r_par;
      r_done <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        if (w_wr[c] && i_cpu_a[1:0] == 2'd0) begin
          r_src_hi[c] <= i_cpu_d;
          r_busy[c]   <= 1'b1;
        end
        if (w_wr[c] && i_cpu_a[1:0] == 2'd1) r_dst_lo[c] <= i_cpu_d;
        if (w_wr[c] && i_cpu_a[1:0] == 2'd2) r_dst_hi[c] <= i_cpu_d;
        if (w_wr[c] && i_cpu_a[1:0] == 2'd3) r_len[c]    <= i_cpu_d;
      end
      case (r_state)
        S_IDLE: begin
          if (|r_busy) begin
            r_state <= S_HALT;
            r_rdy   <= 1'b0;
          end
        end
        S_HALT: begin
          r_ch     <= w_nxt;
          r_src    <= w_ld_src;
          r_dst    <= w_ld_dst;
          r_cnt    <= w_ld_cnt;
          r_state  <= r_par ? S_ALIGN : S_READ;
          r_master <= !r_par;
          r_addr   <= r_par ? 16'h0000 : w_ld_src;
        end
        S_ALIGN: begin
          r_state  <= S_READ;
          r_master <= 1'b1;
          r_addr   <= r_src;
        end
        S_READ: begin
          r_state <= S_WRITE;
          r_wreq  <= 1'b1;
          r_addr  <= r_dst;
          r_dout  <= i_din;
        end
        S_WRITE: begin
          r_wreq  <= 1'b0;
          r_dout  <= '0;
          r_src   <= w_src_inc;
          r_dst   <= w_dst_nxt;
          r_cnt   <= r_cnt - 9'd1;
          r_state <= S_READ;
          r_addr  <= w_src_inc;
          // Last byte: hand the bus straight to the next pending channel, or release the CPU
          if (r_cnt == 9'd1) begin
            r_busy[r_ch] <= 1'b0;
            r_done[r_ch] <= 1'b1;
            r_ch         <= w_nxt;
            r_src        <= w_ld_src;
            r_dst        <= w_ld_dst;
            r_cnt        <= w_ld_cnt;
            r_state      <= w_any ? S_READ : S_IDLE;
            r_master     <= w_any;
            r_rdy        <= !w_any;
            r_addr       <= w_any ? w_ld_src : 16'h0000;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
  assign o_rdy    = r_rdy;
  assign o_master = r_master;
  assign o_addr   = r_addr;
  assign o_dout   = r_dout;
  assign o_wreq   = r_wreq;
  assign o_busy   = r_busy;
  assign o_done   = r_done;
endmodule

// File: tb/tb_cpu_dma.sv
// tb_cpu_dma: table-driven and directed checks of the cpu_dma halt/transfer sequencing.
module tb_cpu_dma;
  logic        clk = 1'b0, rst = 1'b1, cpu_we = 1'b0;
  logic [15:0] cpu_a = '0, addr;
  logic [7:0]  cpu_d = '0, din, dout;
  logic        rdy, master, wreq;
  logic [1:0]  busy, done;
  logic        tpar;
  always #5 clk = ~clk;
  cpu_dma dut (
    .i_clk(clk), .i_rst(rst), .i_cpu_a(cpu_a), .i_cpu_d(cpu_d), .i_cpu_we(cpu_we),
    .i_din(din), .o_rdy(rdy), .o_master(master), .o_addr(addr), .o_dout(dout),
    .o_wreq(wreq), .o_busy(busy), .o_done(done)
  );
  function automatic logic [7:0] memf(input logic [15:0] a);
    return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'h3C;
  endfunction
  function automatic logic [15:0] exp_dst(input logic [15:0] base, input int k);
`ifdef CPU_DMA_DST_INC_EN
    return 16'(base + 16'(k));
`else
    return base;
`endif
  endfunction
  assign din = memf(addr);
  always @(posedge clk) tpar <= rst ? 1'b0 : ~tpar;
  typedef struct {
    logic [1:0]  ch;
    logic [7:0]  src_hi;
    logic [15:0] dst;
    logic [7:0]  len;
    int          pad;
    int          n;
  } vec_t;
  vec_t        vt[5];
  int          n_chk = 0, n_err = 0;
  logic [15:0] q_rd[$], q_wa[$], e_rd[$], e_wa[$];
  logic [7:0]  q_wd[$];
  int          n_low, n_gap, n_halt, exp_gap, n_bad;
  int          dcnt[2], dcyc[2];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask
  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    cpu_a = a; cpu_d = d; cpu_we = 1'b1;
    @(negedge clk);
    cpu_we = 1'b0;
  endtask
  task automatic cfg(input logic [1:0] ch, input logic [7:0] sh, input logic [15:0] dst,
                     input logic [7:0] len);
    wr(16'h4010 | {12'h0, ch, 2'd1}, dst[7:0]);
    wr(16'h4010 | {12'h0, ch, 2'd2}, dst[15:8]);
    wr(16'h4010 | {12'h0, ch, 2'd3}, len);
    wr(16'h4010 | {12'h0, ch, 2'd0}, sh);
  endtask
  task automatic mon(input int budget);
    bit fin, low;
    fin = 0; low = 0;
    q_rd.delete(); q_wa.delete(); q_wd.delete();
    n_low = 0; n_gap = 0; n_halt = 0; exp_gap = 0; n_bad = 0;
    dcnt = '{0, 0}; dcyc = '{0, 0};
    for (int cy = 0; cy < budget && !fin; cy++) begin
      @(negedge clk);
      if (!rdy) begin
        if (!low) begin n_halt++; exp_gap += 1 + int'(tpar); end
        n_low++;
        if (!master) n_gap++;
      end
      low = !rdy;
      if (master && !wreq) q_rd.push_back(addr);
      if (master && wreq) begin q_wa.push_back(addr); q_wd.push_back(dout); end
      if (!master && (wreq || addr != 16'h0 || dout != 8'h0)) n_bad++;
      for (int c = 0; c < 2; c++) if (done[c]) begin dcnt[c]++; dcyc[c] = cy; end
      if (n_low > 0 && rdy && busy == 2'b00) fin = 1;
    end
    chk("mon_finished", 32'(fin), 1);
  endtask
  task automatic expect_x(input logic [7:0] sh, input logic [15:0] dst, input int n);
    for (int k = 0; k < n; k++) begin
      e_rd.push_back(16'({sh, 8'h00} + 16'(k)));
      e_wa.push_back(exp_dst(dst, k));
    end
  endtask
  task automatic cmp(input int ed0, input int ed1);
    int e1, e2, e3;
    e1 = 0; e2 = 0; e3 = 0;
    chk("read_count", q_rd.size(), e_rd.size());
    chk("write_count", q_wa.size(), e_wa.size());
    for (int k = 0; k < e_rd.size(); k++) begin
      if (k < q_rd.size() && q_rd[k] !== e_rd[k]) e1++;
      if (k < q_wa.size() && q_wa[k] !== e_wa[k]) e2++;
      if (k < q_wd.size() && q_wd[k] !== memf(e_rd[k])) e3++;
    end
    chk("read_addr_errs", e1, 0);
    chk("write_addr_errs", e2, 0);
    chk("write_data_errs", e3, 0);
    chk("rdy_low_cycles", n_low, exp_gap + 2 * e_rd.size());
    chk("halt_align_cycles", n_gap, exp_gap);
    chk("halt_count", n_halt, 1);
    chk("bus_quiet_when_not_master", n_bad, 0);
    chk("done0_pulses", dcnt[0], ed0);
    chk("done1_pulses", dcnt[1], ed1);
    e_rd.delete(); e_wa.delete();
  endtask
  initial begin
    int nw, lo, nd;
    vt[0] = '{2'd0, 8'h02, 16'h2004, 8'd4,   0, 4};
    vt[1] = '{2'd0, 8'h02, 16'h2004, 8'd4,   1, 4};
    vt[2] = '{2'd1, 8'h10, 16'h3000, 8'd1,   0, 1};
    vt[3] = '{2'd1, 8'hFF, 16'hFFFE, 8'd0,   0, 256};
    vt[4] = '{2'd0, 8'h7F, 16'h0100, 8'd255, 1, 255};
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset_rdy", rdy, 1);
    chk("reset_master", master, 0);
    chk("reset_wreq", wreq, 0);
    chk("reset_addr", addr, 0);
    chk("reset_dout", dout, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    for (int i = 0; i < 5; i++) begin
      repeat (vt[i].pad) @(negedge clk);
      cfg(vt[i].ch, vt[i].src_hi, vt[i].dst, vt[i].len);
      chk("busy_after_start", busy, 32'(2'b01 << vt[i].ch));
      chk("rdy_before_halt", rdy, 1);
      mon(2000);
      expect_x(vt[i].src_hi, vt[i].dst, vt[i].n);
      cmp(vt[i].ch == 2'd0 ? 1 : 0, vt[i].ch == 2'd1 ? 1 : 0);
    end
    cfg(2'd0, 8'h02, 16'h2004, 8'd4);
    fork
      mon(2000);
      begin
        repeat (3) @(negedge clk);
        wr(16'h4011, 8'h99);
        wr(16'h4013, 8'h01);
      end
    join
    expect_x(8'h02, 16'h2004, 4);
    cmp(1, 0);
    wr(16'h4010, 8'h02);
    mon(2000);
    expect_x(8'h02, 16'h2004, 4);
    cmp(1, 0);
    wr(16'h401C, 8'h12);
    wr(16'h4000, 8'h12);
    wr(16'h4030, 8'h12);
    lo = 0;
    repeat (4) begin @(negedge clk); if (!rdy || busy != 2'b00) lo++; end
    chk("ignored_writes_quiet", lo, 0);
    cfg(2'd1, 8'h21, 16'h3100, 8'd8);
    fork
      mon(3000);
      begin
        repeat (2) @(negedge clk);
        cfg(2'd0, 8'h30, 16'h2200, 8'd2);
      end
    join
    expect_x(8'h21, 16'h3100, 8);
    expect_x(8'h30, 16'h2200, 2);
    cmp(1, 1);
    chk("done1_before_done0", 32'(dcyc[1] < dcyc[0]), 1);
    cfg(2'd0, 8'h40, 16'h2500, 8'd4);
    nw = 0;
    for (int c = 0; c < 100 && nw < 2; c++) begin
      @(negedge clk);
      if (wreq) nw++;
    end
    chk("reached_second_write", nw, 2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_rdy", rdy, 1);
    chk("abort_busy", busy, 0);
    chk("abort_master", master, 0);
    chk("abort_wreq", wreq, 0);
    chk("abort_addr", addr, 0);
    chk("abort_done", done, 0);
    nw = 0; nd = 0; lo = 0;
    repeat (20) begin
      @(negedge clk);
      if (wreq) nw++;
      if (done != 2'b00) nd++;
      if (!rdy) lo++;
    end
    chk("abort_no_wreq", nw, 0);
    chk("abort_no_done", nd, 0);
    chk("abort_rdy_high", lo, 0);
    wr(16'h4010, 8'h05);
    mon(2000);
    expect_x(8'h05, 16'h0000, 256);
    cmp(1, 0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/cpu_dma.md
CPU_DMA -- requirements
Module: cpu_dma

Interface
REQ-001 Parameter CHANNELS, default 2, SHALL set the number of DMA channels, legal range 1..4.
REQ-002 Parameter REG_BASE, default 16'h4010, SHALL set the base address of the 16-byte register window.
REQ-003 CLK  input  1  system clock; all logic SHALL be on posedge CLK.
REQ-004 RST  input  1  reset; synchronous, active-high.
REQ-005 CPU_A  input  16  CPU write address.
REQ-006 CPU_D  input  8  CPU write data.
REQ-007 CPU_WE  input  1  CPU write strobe, sampled on posedge CLK.
REQ-008 DIN  input  8  memory read data.
REQ-009 RDY  output  1  CPU ready; it SHALL drive the CPU CE input, and 0 SHALL stall the CPU.
REQ-010 MASTER  output  1  1 SHALL mean the top level routes ADDR, DOUT and WREQ from this block.
REQ-011 ADDR  output  16  DMA bus address.
REQ-012 DOUT  output  8  DMA write data.
REQ-013 WREQ  output  1  DMA memory write strobe.
REQ-014 BUSY  output  CHANNELS  per-channel pending-or-active flag.
REQ-015 DONE  output  CHANNELS  per-channel one-cycle completion pulse.

Function
REQ-016 Register map: CPU_A[15:4]==REG_BASE[15:4] SHALL decode the window; CPU_A[3:2] SHALL select the channel and CPU_A[1:0] the register.
REQ-017 Registers SHALL be: 0 SRC_HI (a write starts the channel), 1 DST_LO, 2 DST_HI, 3 LEN. LEN=0 SHALL mean 256 bytes.
REQ-018 Writes to a channel number >= CHANNELS SHALL be ignored, and writes to any register of a channel with BUSY=1 SHALL be ignored.
REQ-019 Each transfer SHALL start at source address {SRC_HI,8'h00}; the source SHALL increment per byte and wrap FFFF->0000.
REQ-020 A write to SRC_HI SHALL set that channel's BUSY on the next edge.
REQ-021 The FSM SHALL have the states IDLE, HALT, ALIGN, READ and WRITE.
REQ-022 IDLE -> HALT SHALL occur when any BUSY bit is set; RDY SHALL be 0 in every state except IDLE.
REQ-023 HALT SHALL last 1 cycle and go to ALIGN if the parity bit PAR=1, otherwise to READ.
REQ-024 PAR SHALL toggle every clock from 0 at reset; ALIGN SHALL last 1 cycle and go to READ.
REQ-025 READ state: MASTER=1, ADDR=src, WREQ=0; the closing edge SHALL latch DIN into the buffer.
REQ-026 WRITE state: MASTER=1, ADDR=dst, DOUT=buffer, WREQ=1; the closing edge SHALL advance src, decrement the count, and update dst per REQ-034.
REQ-027 After the last byte's WRITE, the channel's BUSY SHALL clear and DONE SHALL pulse for exactly 1 cycle.
REQ-028 After the last byte's WRITE, the FSM SHALL go to READ of the next pending channel with no new HALT, or to IDLE if none is pending.
REQ-029 Arbitration SHALL be fixed priority, lowest index first, evaluated only at channel boundaries; an active channel SHALL never be preempted.
REQ-030 Latency for a single channel with LEN=N: RDY SHALL be low for 1+PAR+2N cycles.
REQ-031 A start write that arrives while another channel is active SHALL queue and SHALL NOT cause an extra HALT.
REQ-032 MASTER=0 and WREQ=0 SHALL hold in IDLE, HALT and ALIGN; ADDR and DOUT SHALL be 0 in those states.

Reset
REQ-033 RST=1 SHALL, at any state including mid-transfer, force IDLE, RDY=1, MASTER=0, WREQ=0, ADDR=0, DOUT=0, BUSY=0, DONE=0, PAR=0, all registers 0, and abort any transfer without a DONE pulse.

Configuration
REQ-034 Macro CPU_DMA_DST_INC_EN, if defined, SHALL make dst start at {DST_HI,DST_LO} and increment per byte, wrapping FFFF->0000; if undefined, dst SHALL stay fixed at {DST_HI,DST_LO} for every byte (OAM-port style).

Verification
REQ-035 Even PAR: ch0 DST=2004, LEN=4, SRC_HI=02 -> RDY low 9 cycles; reads 0200..0203, writes 2004 x4 with the read data in order; DONE[0] is 1 cycle.
REQ-036 Odd PAR: same setup -> exactly one ALIGN cycle and RDY low 10 cycles.
REQ-037 LEN=0, SRC_HI=FF, DST_INC_EN defined, DST=FFFE -> 256 bytes; src FF00..FFFF; dst wraps FFFF->0000 after 2 bytes; RDY low 513 or 514 cycles.
REQ-038 ch1 started, then ch0 started during ch1's transfer -> ch1 completes first, then ch0 READ immediately with no HALT; DONE[1] precedes DONE[0].
REQ-039 Write DST_LO to busy ch0 mid-transfer -> ignored, destination unchanged; write to channel 3 with CHANNELS=2 -> no effect.
REQ-040 RST asserted in the WRITE state of byte 2 -> next cycle IDLE, RDY=1, BUSY=0, no DONE pulse, and no further WREQ.
